fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the pipelined processor, the successor to the fixed 32-bit, always-PC+4 fetch stage. Holds the PC, drives the combinational instruction memory, and accepts a branch/jump redirect from later stages. Buffers fetched instructions in a small flushable queue and hands them to decode over a valid/ready handshake, so decode stalls no longer lose or duplicate instructions.

## Interface
- XLEN, 32, PC and data width in bits.
- IMEM_AW, 8, instruction-memory word-address width.
- QDEPTH, 4, fetch-queue entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  IMEM_AW  word address to instruction memory; equals pc[IMEM_AW+1:2].
- imem_data  in  32  instruction read combinationally from imem_addr in the same cycle.
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and treated as 0.
- d_valid  out  1  queue head is valid.
- d_ready  in  1  decode accepts the head this cycle.
- d_instr  out  32  instruction at the queue head.
- d_pc  out  XLEN  PC of the instruction at the queue head.
- perf_fetched  out  32  count of instructions pushed into the queue.
- perf_flushed  out  32  count of queue entries discarded by redirects.

## Operation
- pop = d_valid & d_ready. The head entry is removed at the clock edge.
- push = !redirect_valid & (count < QDEPTH | pop). Writes {pc, imem_data} at the tail. The PC then becomes pc + 4, wrapping modulo 2^XLEN.
- A full queue with a simultaneous pop pushes and pops in the same cycle, and count is unchanged.
- Redirect has priority over push:
  - A pop in the same cycle still completes, because decode has consumed that entry.
  - All remaining entries are discarded: count goes to 0 and the head and tail pointers are equalised.
  - The PC is loaded with {redirect_pc[XLEN-1:2], 2'b00}. There is no push that cycle.
- d_valid = (count != 0). d_instr and d_pc come from the head entry and are undefined when d_valid is 0.
- Queue pointers wrap modulo QDEPTH. Count ranges from 0 to QDEPTH.
- PC bits above IMEM_AW+1 do not affect imem_addr; the memory image is aliased.
- Reset, including assertion in the middle of operation:
  - pc = RESET_PC, count = 0, pointers = 0.
  - d_valid = 0, perf_fetched = 0, perf_flushed = 0.
  - imem_addr = RESET_PC[IMEM_AW+1:2].
  - Queue storage contents are not reset.

## Timing
- Fetch-to-decode latency is 1 cycle: an instruction pushed at edge N is visible on d_* after edge N.
- First cycle after reset release: fetch RESET_PC. d_valid is 1 in the next cycle with d_pc = RESET_PC.
- Redirect sampled at edge N:
  - The target is fetched in cycle N+1 and presented on d_* after edge N+1.
  - This is a one-cycle bubble.
- With d_ready held at 1 and no redirects, one instruction is delivered per cycle.
- With d_ready held at 0, the queue fills in QDEPTH cycles, after which the PC holds.
- Combinational paths: pc → imem_addr → imem_data → queue write, and d_ready → push.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_fetched increments by 1 on every push.
  - perf_flushed adds (count − pop) on every redirect.
  - Both counters wrap modulo 2^32.
- FETCH_PERF_CNT_EN undefined: the counters are not built and both outputs are tied to 0. The ports remain present.

## Structure
- Shared package fetch_pkg holds:
  - the XLEN default;
  - the instruction width constant (32);
  - the queue entry struct fetch_entry_t {pc, instr};
  - the PC increment constant (4).
- Sub-module fetch_queue: a synchronous flushable FIFO of fetch_entry_t with push, pop, flush, count, and head outputs, parameterised by QDEPTH.
- fetch_unit contains the PC register, push/redirect logic and perf counters, and instantiates fetch_queue.

## Test plan
- Reset with RESET_PC=0x100, d_ready=1, memory word k = 0xA000_0000+k → d_pc sequence 0x100, 0x104, 0x108… with d_instr 0xA000_0040, 0xA000_0041, …, one per cycle.
- Hold d_ready=0 for 10 cycles (QDEPTH=4), then release → d_valid stays 1, the PC holds after 4 pushes, and the first outputs after release are 0x100–0x10C in order with no loss or duplication.
- Redirect to 0x203 while the queue holds 3 entries and d_ready=1 → the head is popped, 2 are flushed, the next d_pc is 0x200 after a 1-cycle bubble, and perf_flushed = 2 (macro on).
- Queue full, d_ready=1 and push in the same cycle → count stays 4, order is preserved, and there is no drop.
- Assert reset mid-stream with the queue partially full → d_valid is 0 immediately, and the first d_pc after release = RESET_PC.
- Build without FETCH_PERF_CNT_EN → perf_fetched and perf_flushed read 0 throughout the scenarios above, and functional outputs are identical to the macro-on build.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    localparam int XLEN   = 32;
    localparam int ILEN   = 32;
    localparam int PC_INC = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Flushable synchronous FIFO of fetch entries; flush empties it by snapping head to tail.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(QDEPTH),
    localparam int CW      = $clog2(QDEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output logic [CW-1:0] count,
    output entry_t        head
);
    entry_t        storage [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // any pop this cycle is already consumed; everything else goes
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) storage[wr_ptr_q] <= wdata;
    end

    assign count = count_q;
    assign head  = storage[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, imem drive, redirect handling, fetch queue to decode.
// Optional perf counters built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              IMEM_AW  = 8,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             CW       = $clog2(QDEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               d_valid,
    input  logic               d_ready,
    output logic [ILEN-1:0]    d_instr,
    output logic [XLEN-1:0]    d_pc,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count;
    logic            push, pop;
    entry_t          wdata, head;

    assign pop   = d_valid & d_ready;
    assign push  = !redirect_valid & ((count < CW'(QDEPTH)) | pop);
    assign wdata = '{pc: pc_q, instr: imem_data};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc & ~XLEN'(3);
        else if (push)      pc_d = pc_q + XLEN'(PC_INC);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_queue #(.QDEPTH(QDEPTH), .entry_t(entry_t)) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign d_valid   = (count != '0);
    assign d_instr   = head.instr;
    assign d_pc      = head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;

    always_comb begin
        fetched_d = fetched_q + 32'(push);
        flushed_d = flushed_q;
        if (redirect_valid) flushed_d = flushed_q + 32'(count) - 32'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`else
    assign perf_fetched = '0;
    assign perf_flushed = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam int          QDEPTH   = 4;
    localparam int          IMEM_AW  = 8;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clock = 0;
    logic        reset = 0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        d_valid;
    logic        d_ready = 0;
    logic [31:0] d_instr, d_pc, perf_fetched, perf_flushed;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetched, m_flushed;

    always #5 clock = ~clock;

    // memory word k holds 0xA000_0000 + k
    assign imem_data = 32'hA000_0000 + {24'b0, imem_addr};

    fetch_unit #(.XLEN(32), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_instr        (d_instr),
        .d_pc           (d_pc),
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'hA000_0000 + {24'b0, pc[9:2]};
    endfunction

    task automatic check_outputs();
        chk("d_valid", 64'(d_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("d_pc", 64'(d_pc), 64'(mq[0][63:32]));
            chk("d_instr", 64'(d_instr), 64'(mq[0][31:0]));
        end
        chk("imem_addr", 64'(imem_addr), 64'(m_pc[9:2]));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`else
        chk("perf_fetched", 64'(perf_fetched), 64'd0);
        chk("perf_flushed", 64'(perf_flushed), 64'd0);
`endif
    endtask

    // entered and left just after a falling edge
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bit pop, push;
        d_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        #1;
        check_outputs();
        @(posedge clock);
        pop  = (mq.size() != 0) && rdy;
        push = !rv && ((mq.size() < QDEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (rv) begin
            m_flushed += 32'(mq.size());
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (push) begin
            mq.push_back({m_pc, mem_word(m_pc)});
            m_fetched += 1;
            m_pc += 4;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 0;
        d_ready = 0;
        redirect_valid = 0;
        mq.delete();
        m_pc = RESET_PC;
        m_fetched = 0;
        m_flushed = 0;
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        // streaming with decode always ready
        repeat (8) step(1, 0, 0);
        // stall fills queue, PC holds, then drain in order
        do_reset();
        repeat (10) step(0, 0, 0);
        chk("pc_hold", 64'(imem_addr), 64'((RESET_PC + 32'd16) >> 2));
        repeat (8) step(1, 0, 0);
        // redirect with three queued entries and a pop
        do_reset();
        repeat (3) step(0, 0, 0);
        step(1, 1, 32'h203);
        chk("bubble", 64'(d_valid), 64'd0);
        repeat (4) step(1, 0, 0);
        // full queue with simultaneous push/pop
        repeat (6) step(0, 0, 0);
        repeat (6) step(1, 0, 0);
        // PC wrap and memory aliasing
        step(1, 1, 32'hFFFF_FFF9);
        repeat (5) step(1, 0, 0);
        // reset in the middle of a partially full queue
        repeat (2) step(0, 0, 0);
        do_reset();
        repeat (3) step(1, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
